// File: rtl/sum_uart_pkg.sv
// Shared definitions for the sum_uart serial transmitter (and the planned receiver).
//   tx_state_t     : transmitter FSM states
//   TX_IDLE_LEVEL  : line level while idle and during stop bits
//   START_LEVEL    : line level of the start bit
//   frame_cycles() : clock cycles in one complete frame for a given configuration
package sum_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic TX_IDLE_LEVEL = 1'b1;
    localparam logic START_LEVEL   = 1'b0;

    // Start bit + data bits + optional parity bit + stop bits, each one bit period long.
    function automatic int unsigned frame_cycles(
        input int unsigned clks_per_bit,
        input int unsigned data_w,
        input int unsigned parity_en,
        input int unsigned stop_bits
    );
        int unsigned par_bits;
        par_bits = (parity_en != 0) ? 32'd1 : 32'd0;
        return (32'd1 + data_w + par_bits + stop_bits) * clks_per_bit;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer for the sum_uart serial blocks.
// Counts 0..CLKS_PER_BIT-1 and wraps; bit_end is high during the terminal count.
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset (counter to 0)
//   clear   : hold the counter at 0 (used while the line is idle)
//   bit_end : high in the last cycle of each bit period
module uart_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_end
);

    localparam int unsigned         CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]    LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign bit_end = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear || bit_end) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sum_uart_tx.sv
// UART transmitter for result bytes leaving the tile on one output pin.
// A one-entry holding register accepts words on a valid/ready handshake; the FSM shifts each
// word out LSB-first as start bit, data bits, optional parity bit and 1 or 2 stop bits.
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset; aborts any frame, line goes high at once
//   in_data    : word to transmit
//   in_valid   : in_data is valid
//   in_ready   : holding register empty (never depends on in_valid)
//   tx         : registered serial line, idle high
//   busy       : FSM active or a word is waiting in the holding register
//   frame_done : one-cycle pulse in the last cycle of the final stop bit
module sum_uart_tx
    import sum_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx,
    output logic              busy,
    output logic              frame_done
);

    localparam int unsigned              BIT_CNT_W   = $clog2(DATA_W) + 1;
    localparam logic [BIT_CNT_W-1:0]     DATA_LAST   = BIT_CNT_W'(DATA_W - 1);
    localparam logic [BIT_CNT_W-1:0]     STOP_LAST   = BIT_CNT_W'(STOP_BITS - 1);
    localparam logic                     PARITY_INIT = (PARITY_ODD != 0);
    localparam bit                       HAS_PARITY  = (PARITY_EN != 0);

    tx_state_t              state_q, state_d;
    logic [DATA_W-1:0]      hold_q, hold_d;
    logic                   hold_full_q, hold_full_d;
    logic [DATA_W-1:0]      shift_q, shift_d;
    logic                   parity_q, parity_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic                   tx_q, tx_d;

    logic bit_end;
    logic timer_clear;
    logic load;        // FSM takes the held word this edge
    logic accept;      // handshake this edge
    logic data_last;
    logic stop_last;

    assign timer_clear = (state_q == IDLE);
    assign accept      = in_valid && in_ready;
    assign data_last   = (bit_cnt_q == DATA_LAST);
    assign stop_last   = (bit_cnt_q == STOP_LAST);

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .bit_end (bit_end)
    );

    // ---------------------------------------------------------------- state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (hold_full_q) begin
                    state_d = START;
                    load    = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end && data_last) begin
                    state_d = HAS_PARITY ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end && stop_last) begin
                    // A waiting word starts immediately: no idle cycle between frames.
                    if (hold_full_q) begin
                        state_d = START;
                        load    = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------- datapath next state
    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        bit_cnt_d   = bit_cnt_q;

        // accept and load are exclusive: load needs hold_full, accept needs !hold_full.
        if (accept) begin
            hold_d      = in_data;
            hold_full_d = 1'b1;
        end

        if (load) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            parity_d    = PARITY_INIT;
            bit_cnt_d   = '0;
        end else if (bit_end) begin
            case (state_q)
                DATA: begin
                    shift_d   = shift_q >> 1;
                    parity_d  = parity_q ^ shift_q[0];
                    bit_cnt_d = data_last ? '0 : bit_cnt_q + BIT_CNT_W'(1);
                end
                STOP: begin
                    bit_cnt_d = stop_last ? '0 : bit_cnt_q + BIT_CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            bit_cnt_q   <= '0;
            tx_q        <= TX_IDLE_LEVEL;
        end else begin
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_q        <= tx_d;
        end
    end

    // ---------------------------------------------------------------- outputs
    // tx is registered from the next-state view so the line changes on the same edge
    // the FSM changes state.
    always_comb begin
        case (state_d)
            IDLE:    tx_d = TX_IDLE_LEVEL;
            START:   tx_d = START_LEVEL;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = parity_d;
            STOP:    tx_d = TX_IDLE_LEVEL;
            default: tx_d = TX_IDLE_LEVEL;
        endcase
        in_ready   = !hold_full_q;
        busy       = (state_q != IDLE) || hold_full_q;
        frame_done = (state_q == STOP) && bit_end && stop_last;
    end

    assign tx = tx_q;

`ifndef SYNTHESIS
    localparam int unsigned FRAME_LEN =
        frame_cycles(CLKS_PER_BIT, DATA_W, PARITY_EN, STOP_BITS);

    // Cycle index within the current frame (1 in the first start-bit cycle).
    int unsigned frame_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= 0;
        end else if (load) begin
            frame_cnt_q <= 1;
        end else if (state_q != IDLE) begin
            frame_cnt_q <= frame_cnt_q + 1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(accept && load));
            if (frame_done) begin
                assert (frame_cnt_q == FRAME_LEN);
            end
        end
    end
`endif

endmodule

// File: tb/tb_sum_uart_tx.sv
// Self-checking bench for sum_uart_tx. Three instances with different configurations share
// clock and reset. A driver issues words under a holding-register model that predicts when
// each word is accepted and when its frame must start; a per-instance monitor reconstructs
// every frame from the line and compares it with the expected start cycle, bit sequence,
// busy level and frame_done pulse.
`timescale 1ns/1ps
module tb_sum_uart_tx;
    import sum_uart_pkg::*;

    localparam int NDUT = 3;

    typedef struct packed {
        logic [7:0]  data;
        logic [31:0] start;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data_a  [NDUT];
    logic       in_valid_a [NDUT];
    logic       in_ready_a [NDUT];
    logic       tx_a       [NDUT];
    logic       busy_a     [NDUT];
    logic       fd_a       [NDUT];

    int unsigned cyc = 0;
    int          vectors = 0;
    int          errors = 0;

    exp_t        q0[$];
    exp_t        q1[$];
    exp_t        q2[$];
    logic [7:0]  stim[$];
    int unsigned hold_until [NDUT];
    int unsigned last_end   [NDUT];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sum_uart_tx #(.CLKS_PER_BIT(4), .DATA_W(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
    u_dut0 (.clk(clk), .rst(rst), .in_data(in_data_a[0]), .in_valid(in_valid_a[0]),
            .in_ready(in_ready_a[0]), .tx(tx_a[0]), .busy(busy_a[0]), .frame_done(fd_a[0]));

    sum_uart_tx #(.CLKS_PER_BIT(2), .DATA_W(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2))
    u_dut1 (.clk(clk), .rst(rst), .in_data(in_data_a[1]), .in_valid(in_valid_a[1]),
            .in_ready(in_ready_a[1]), .tx(tx_a[1]), .busy(busy_a[1]), .frame_done(fd_a[1]));

    sum_uart_tx #(.CLKS_PER_BIT(3), .DATA_W(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
    u_dut2 (.clk(clk), .rst(rst), .in_data(in_data_a[2]), .in_valid(in_valid_a[2]),
            .in_ready(in_ready_a[2]), .tx(tx_a[2]), .busy(busy_a[2]), .frame_done(fd_a[2]));

    // ------------------------------------------------------------ configuration per instance
    function automatic int unsigned cfg_cpb(input int id);
        case (id)
            0:       return 4;
            1:       return 2;
            default: return 3;
        endcase
    endfunction

    function automatic int unsigned cfg_par_en(input int id);
        return (id == 0) ? 0 : 1;
    endfunction

    function automatic int unsigned cfg_par_odd(input int id);
        return (id == 1) ? 1 : 0;
    endfunction

    function automatic int unsigned cfg_stop(input int id);
        return (id == 1) ? 2 : 1;
    endfunction

    function automatic int unsigned cfg_frame(input int id);
        return frame_cycles(cfg_cpb(id), 8, cfg_par_en(id), cfg_stop(id));
    endfunction

    // Line level of bit slot idx of a frame carrying d.
    function automatic logic exp_bit(input int id, input logic [7:0] d, input int unsigned idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
        if (cfg_par_en(id) != 0 && idx == 9) return (^d) ^ (cfg_par_odd(id) != 0);
        return 1'b1;
    endfunction

    // ------------------------------------------------------------ scoreboard queues
    function automatic int q_size(input int id);
        case (id)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic q_push(input int id, input exp_t e);
        case (id)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic q_pop(input int id, output exp_t e);
        case (id)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
    endtask

    task automatic check(input bit ok, input string name, input int act, input int req);
        vectors++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ------------------------------------------------------------ monitor
    task automatic monitor(input int id);
        int unsigned c;
        int unsigned n;
        exp_t        e;
        logic        exp_tx;
        bit          ok_bits;
        int          bad_k, bad_act, bad_req, fd_count, fd_pos;
        c = cfg_cpb(id);
        n = cfg_frame(id);
        forever begin
            @(negedge clk);
            if (rst) continue;
            if (tx_a[id] !== 1'b0) begin
                check(fd_a[id] === 1'b0, $sformatf("idle_frame_done dut%0d", id),
                      int'(fd_a[id]), 0);
                continue;
            end
            if (q_size(id) == 0) begin
                check(1'b0, $sformatf("unexpected_frame dut%0d", id), int'(cyc), -1);
                repeat (n - 1) @(negedge clk);
                continue;
            end
            q_pop(id, e);
            check(cyc == e.start, $sformatf("start_cycle dut%0d data=%02h", id, e.data),
                  int'(cyc), int'(e.start));
            ok_bits  = 1'b1;
            bad_k    = 0;
            bad_act  = 0;
            bad_req  = 0;
            fd_count = 0;
            fd_pos   = 0;
            for (int unsigned k = 0; k < n; k++) begin
                if (k != 0) @(negedge clk);
                exp_tx = exp_bit(id, e.data, k / c);
                if (ok_bits && (tx_a[id] !== exp_tx || busy_a[id] !== 1'b1)) begin
                    ok_bits = 1'b0;
                    bad_k   = int'(k);
                    bad_act = int'({busy_a[id], tx_a[id]});
                    bad_req = int'({1'b1, exp_tx});
                end
                if (fd_a[id] === 1'b1) begin
                    fd_count++;
                    fd_pos = int'(k) + 1;
                end
            end
            check(ok_bits, $sformatf("frame_bits dut%0d data=%02h frame_cycle=%0d {busy,tx}",
                  id, e.data, bad_k + 1), bad_act, bad_req);
            check(fd_count == 1, $sformatf("frame_done_count dut%0d", id), fd_count, 1);
            check(fd_pos == int'(n), $sformatf("frame_done_cycle dut%0d", id), fd_pos, int'(n));
        end
    endtask

    // ------------------------------------------------------------ driver with hold model
    task automatic send(input int id, input int unsigned max_gap);
        int unsigned idx, gap, guard, n, a, s;
        logic        exp_rdy;
        exp_t        e;
        idx   = 0;
        gap   = 0;
        guard = 0;
        n     = cfg_frame(id);
        while (idx < stim.size()) begin
            @(negedge clk);
            exp_rdy = (cyc >= hold_until[id]);
            check(in_ready_a[id] === exp_rdy, $sformatf("in_ready dut%0d", id),
                  int'(in_ready_a[id]), int'(exp_rdy));
            if (gap != 0) begin
                in_valid_a[id] = 1'b0;
                gap--;
            end else begin
                in_data_a[id]  = stim[idx];
                in_valid_a[id] = 1'b1;
                if (in_ready_a[id] === 1'b1) begin
                    // Accepted on the coming edge; the frame starts one cycle later, or
                    // straight after the frame already scheduled if that ends later.
                    a = cyc + 1;
                    s = (a + 1 > last_end[id] + 1) ? a + 1 : last_end[id] + 1;
                    last_end[id]   = s + n - 1;
                    hold_until[id] = s;
                    e.data  = stim[idx];
                    e.start = s;
                    q_push(id, e);
                    idx++;
                    gap = (max_gap == 0) ? 0 : $urandom_range(max_gap, 0);
                end
            end
            guard++;
            if (guard > 5000) begin
                check(1'b0, $sformatf("send_timeout dut%0d", id), int'(idx), stim.size());
                break;
            end
        end
        @(negedge clk);
        in_valid_a[id] = 1'b0;
    endtask

    task automatic drain(input int id);
        int unsigned guard;
        guard = 0;
        while (cyc <= last_end[id] + 2 && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        check(q_size(id) == 0, $sformatf("frames_outstanding dut%0d", id), q_size(id), 0);
        check(busy_a[id] === 1'b0 && tx_a[id] === 1'b1, $sformatf("idle_after dut%0d", id),
              int'({busy_a[id], tx_a[id]}), 1);
    endtask

    task automatic load_stim(input int unsigned cnt, input logic [31:0] w);
        stim.delete();
        for (int unsigned i = 0; i < cnt; i++) stim.push_back(w[8*i +: 8]);
    endtask

    task automatic run_words(input int id, input int unsigned cnt, input logic [31:0] w);
        load_stim(cnt, w);
        send(id, 0);
        drain(id);
    endtask

    // ------------------------------------------------------------ main sequence
    initial begin
        bit ok;
        rst = 1'b1;
        for (int i = 0; i < NDUT; i++) begin
            in_valid_a[i] = 1'b0;
            in_data_a[i]  = 8'h00;
            hold_until[i] = 0;
            last_end[i]   = 0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < NDUT; i++) begin
            check({tx_a[i], busy_a[i], in_ready_a[i], fd_a[i]} === 4'b1010,
                  $sformatf("reset_state dut%0d {tx,busy,rdy,fd}", i),
                  int'({tx_a[i], busy_a[i], in_ready_a[i], fd_a[i]}), 4'b1010);
        end
        rst = 1'b0;

        repeat (100) begin
            @(negedge clk);
            for (int i = 0; i < NDUT; i++) begin
                check({tx_a[i], busy_a[i], in_ready_a[i], fd_a[i]} === 4'b1010,
                      $sformatf("idle_state dut%0d {tx,busy,rdy,fd}", i),
                      int'({tx_a[i], busy_a[i], in_ready_a[i], fd_a[i]}), 4'b1010);
            end
        end

        // Reset in the middle of a frame.
        @(negedge clk);
        in_data_a[0]  = 8'hA5;
        in_valid_a[0] = 1'b1;
        @(negedge clk);
        in_valid_a[0] = 1'b0;
        repeat (9) @(negedge clk);
        check(busy_a[0] === 1'b1, "busy_mid_frame", int'(busy_a[0]), 1);
        rst = 1'b1;
        #1;
        check({tx_a[0], busy_a[0], in_ready_a[0]} === 3'b101, "reset_mid_frame {tx,busy,rdy}",
              int'({tx_a[0], busy_a[0], in_ready_a[0]}), 3'b101);

        // A handshake while reset is held is discarded.
        @(negedge clk);
        in_data_a[0]  = 8'h3C;
        in_valid_a[0] = 1'b1;
        @(negedge clk);
        in_valid_a[0] = 1'b0;
        rst = 1'b0;
        ok = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (tx_a[0] !== 1'b1 || busy_a[0] !== 1'b0) ok = 1'b0;
        end
        check(ok, "handshake_in_reset_dropped", int'(!ok), 0);

        fork
            monitor(0);
            monitor(1);
            monitor(2);
        join_none

        for (int id = 0; id < NDUT; id++) begin
            run_words(id, 1, 32'h0000_00A5);
            run_words(id, 1, 32'h0000_0001);
            run_words(id, 1, 32'h0000_00FF);
            run_words(id, 2, 32'h0000_0F55);
            run_words(id, 3, 32'h0033_2211);
            stim.delete();
            for (int i = 0; i < 14; i++) stim.push_back(8'($urandom));
            send(id, 2 * cfg_frame(id));
            drain(id);
        end

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "simulation did not complete");
    end

endmodule

// File: doc/sum_uart_tx.md
Name: sum_uart_tx

Overview:
Serial transmitter that returns result bytes (e.g. the ui_in + uio_in sum) off-chip over one output pin as UART frames.
- Accepts 8-bit parallel words on a valid/ready handshake into a one-entry holding register.
- Shifts each word out LSB-first as: start bit, data bits, optional parity, 1 or 2 stop bits.
- Sits between the tile's arithmetic datapath and one uo_out bit; it is the serial-output end of the data path.

Parameters:
CLKS_PER_BIT, 16, clk cycles per serial bit; legal range 2..65535.
DATA_W, 8, data bits per frame; legal range 5..8.
PARITY_EN, 0, 1 inserts a parity bit after the data bits.
PARITY_ODD, 0, 0 selects even parity, 1 selects odd parity; ignored when PARITY_EN=0.
STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
clk  input  1  single clock; all state is updated on the rising edge.
rst  input  1  asynchronous, active-high reset.
in_data  input  DATA_W  word to transmit.
in_valid  input  1  in_data is valid.
in_ready  output  1  holding register empty; equals !hold_full.
tx  output  1  serial line, idle high; registered.
busy  output  1  high whenever the FSM is not IDLE or hold_full=1.
frame_done  output  1  one-cycle pulse in the last cycle of the final stop bit.

Behaviour:
- Reset (async assert, sync release): tx=1, busy=0, frame_done=0, hold_full=0 (so in_ready=1), FSM=IDLE, bit timer=0.
- Handshakes coinciding with rst are discarded.
- Reset mid-frame aborts the frame; tx returns high immediately.
- Handshake: transfer occurs on a rising edge with in_valid & in_ready. in_data is captured into hold and hold_full is set.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE->START on any edge where hold_full=1. On that edge:
  - the shifter loads hold;
  - hold_full clears;
  - the parity accumulator initialises to PARITY_ODD;
  - tx is registered 0.
- tx therefore falls on the edge after the handshake edge (1-cycle latency).
- Each state holds tx for exactly CLKS_PER_BIT cycles, counted by the bit timer. Timer counts 0..CLKS_PER_BIT-1; a bit ends at terminal count.
- START->DATA. In DATA, tx=shifter[0]; the shifter shifts right at each bit end.
  - A bit counter 0..DATA_W-1 tracks position.
  - After bit DATA_W-1: go to PARITY if PARITY_EN, else STOP.
- PARITY: tx = XOR of all data bits XOR PARITY_ODD. Then go to STOP.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. frame_done pulses in the final cycle.
  - At that end: if hold_full=1, go directly to START with no idle cycle (back-to-back frames); otherwise go to IDLE.
- hold is writable during any FSM state. A new word accepted during a frame waits in hold; in_ready=0 until the FSM consumes it.
- Same-edge handshake and hold consumption: IDLE or end of STOP with hold_full=1 forces in_ready=0, so no conflict arises. in_ready is never combinationally dependent on in_valid.
- Frame length = (1 + DATA_W + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles.
- Counter widths: timer = $clog2(CLKS_PER_BIT); bit counter = $clog2(DATA_W)+1. No counter wraps outside its terminal compare.

Decomposition:
- Shared package sum_uart_pkg holds:
  - state enum tx_state_t {IDLE, START, DATA, PARITY, STOP};
  - constants TX_IDLE_LEVEL=1'b1 and START_LEVEL=1'b0;
  - function frame_cycles(CLKS_PER_BIT, DATA_W, PARITY_EN, STOP_BITS), used by RTL assertions and the bench.
- One sub-module: uart_bit_timer (parameter CLKS_PER_BIT).
  - Inputs: clk, rst, clear.
  - Output: bit_end pulse on terminal count.
  - Reused by the planned receiver.

Test Plan:
- Reset, then idle: CLKS_PER_BIT=4, no valid -> tx=1, busy=0, in_ready=1 for 100 cycles. Assert rst mid-frame -> tx=1 and FSM=IDLE in the same cycle.
- Single byte 0xA5, defaults with CLKS_PER_BIT=4:
  - tx falls 1 cycle after the handshake;
  - bit sequence is 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles, 40 cycles total;
  - frame_done pulses once at cycle 40.
- Parity: PARITY_EN=1 with 0xA5 -> parity bit 0 (even) and 1 (PARITY_ODD=1). With 0x01 -> 1 (even) and 0 (odd). Frame is 44 cycles.
- Back-to-back: hold in_valid high with 0x55 then 0x0F -> second accepted while the first shifts; in_ready=0 until the first frame's START; no idle cycle between frames; 80 contiguous cycles.
- Backpressure: offer 3 words at once -> exactly 2 accepted before in_ready drops; the third is accepted at the first frame's end; all three are transmitted in order.
- STOP_BITS=2, CLKS_PER_BIT=2, 0xFF -> 2-cycle start, 16 cycles of 1s, 4 stop cycles; frame_done fires on the last stop cycle.
